traffic_phase_ctrl: RTL and testbench

Parametrised N-phase intersection controller: the successor of the two-way light sequencer. It cycles green → yellow → all-red clearance through up to NPHASE signal groups with built-in per-state countdown timers. It adds a per-phase enable mask, latched pedestrian requests with walk extension, police all-red override, flash mode and pause. It sits between the panel/switch inputs and the lamp and 7-segment drivers, and replaces the external rest-time counter handshake.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_countdown.sv | 37 +++
 rtl/traffic_phase_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-phase intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_CLEAR,
    ST_GREEN,
    ST_YELLOW,
    ST_POLICE,
    ST_FLASH
  } state_e;

  localparam int unsigned LAMP_RED    = 0;
  localparam int unsigned LAMP_YELLOW = 1;
  localparam int unsigned LAMP_GREEN  = 2;
  localparam int unsigned LAMP_W      = 3;

  // Duration must be nonzero and fit in a tw-bit countdown.
  function automatic bit dur_ok(input int unsigned d, input int unsigned tw);
    return (d >= 1) && (64'(d) < (64'(1) << tw));
  endfunction

endpackage

// File: rtl/traffic_countdown.sv
// Per-state tick countdown: loads a duration, decrements on tick, flags the final tick.
module traffic_countdown #(
  parameter int unsigned TW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          tick_i,
  input  logic          hold_i,
  output logic [TW-1:0] rest_time_o,
  output logic          expire_c_o
);

  logic [TW-1:0] rest_q, rest_d;

  assign expire_c_o  = tick_i && !hold_i && (rest_q == TW'(1));
  assign rest_time_o = rest_q;

  always_comb begin
    rest_d = rest_q;
    if (load_i) begin
      rest_d = load_val_i;
    end else if (tick_i && !hold_i && (rest_q > TW'(1))) begin
      rest_d = rest_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rest_q <= '0;
    end else begin
      rest_q <= rest_d;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection controller: green/yellow/clearance sequencing with
// pedestrian walk extension, police all-red, flash mode and pause.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NPHASE   = 4,
  parameter int unsigned TW       = 7,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned CLEAR_T  = 2,
  parameter int unsigned PED_T    = 30
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      en,
  input  logic                      pause,
  input  logic                      police,
  input  logic                      flash,
  input  logic [NPHASE-1:0]         phase_en,
  input  logic [NPHASE-1:0]         ped_req,
  output logic [NPHASE-1:0]         red,
  output logic [NPHASE-1:0]         yellow,
  output logic [NPHASE-1:0]         green,
  output logic [NPHASE-1:0]         walk,
  output logic [$clog2(NPHASE)-1:0] phase_idx,
  output logic [TW-1:0]             rest_time,
  output logic [NPHASE-1:0]         ped_pend
);

  localparam int unsigned PW = $clog2(NPHASE);
  localparam bit PARAMS_OK = (NPHASE >= 2) && (NPHASE <= 8) &&
                             dur_ok(GREEN_T, TW) && dur_ok(YELLOW_T, TW) &&
                             dur_ok(CLEAR_T, TW) && dur_ok(PED_T, TW) &&
                             (PED_T >= GREEN_T);

  typedef logic [NPHASE-1:0] mask_t;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  mask_t         red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  mask_t         walk_q, walk_d, pend_q, pend_d, served;
  logic          flash_q, flash_d;
  logic          cd_load, cd_expire;
  logic [TW-1:0] cd_val;
  logic [PW:0]   nxt;
  logic [LAMP_W-1:0] lamp;

  // First enabled phase after cur, cur itself last; MSB flags that one was found.
  function automatic logic [PW:0] next_phase(input logic [PW-1:0] cur, input mask_t mask);
    logic [PW:0] r;
    r = '0;
    for (int k = int'(NPHASE); k >= 1; k--) begin
      if (mask[PW'((int'(cur) + k) % int'(NPHASE))]) begin
        r = {1'b1, PW'((int'(cur) + k) % int'(NPHASE))};
      end
    end
    return r;
  endfunction

  assign nxt = next_phase(phase_q, phase_en);

  traffic_countdown #(.TW(TW)) u_countdown (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cd_load),
    .load_val_i (cd_val),
    .tick_i     (tick),
    .hold_i     (pause),
    .rest_time_o(rest_time),
    .expire_c_o (cd_expire)
  );

  // Next state, countdown load and pedestrian bookkeeping.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pend_d  = pend_q | ped_req;
    walk_d  = walk_q;
    cd_load = 1'b0;
    cd_val  = '0;
    if (!en) begin
      state_d = ST_OFF;
      cd_load = 1'b1;
      walk_d  = '0;
    end else if (police) begin
      state_d = ST_POLICE;
      cd_load = 1'b1;
      walk_d  = '0;
    end else if (flash) begin
      state_d = ST_FLASH;
      cd_load = 1'b1;
      walk_d  = '0;
    end else if (!pause) begin
      unique case (state_q)
        ST_OFF, ST_POLICE, ST_FLASH: begin
          state_d = ST_CLEAR;
          cd_load = 1'b1;
          cd_val  = TW'(CLEAR_T);
        end
        ST_CLEAR: begin
          if (cd_expire) begin
            cd_load = 1'b1;
            cd_val  = TW'(CLEAR_T);
            if (nxt[PW]) begin
              state_d = ST_GREEN;
              phase_d = nxt[PW-1:0];
              cd_val  = TW'(GREEN_T);
              walk_d  = '0;
              if (pend_d[nxt[PW-1:0]]) begin
                cd_val                 = TW'(PED_T);
                pend_d[nxt[PW-1:0]]    = 1'b0;
                walk_d                 = mask_t'(1) << nxt[PW-1:0];
              end
            end
          end
        end
        ST_GREEN: begin
          if (cd_expire) begin
            state_d = ST_YELLOW;
            cd_load = 1'b1;
            cd_val  = TW'(YELLOW_T);
            walk_d  = '0;
          end
        end
        ST_YELLOW: begin
          if (cd_expire) begin
            state_d = ST_CLEAR;
            cd_load = 1'b1;
            cd_val  = TW'(CLEAR_T);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Lamp pattern for the state being entered, so lamps change on the deciding edge.
  always_comb begin
    served  = mask_t'(1) << phase_d;
    lamp    = '0;
    flash_d = 1'b1;
    yellow_d = '0;
    green_d  = '0;
    red_d    = '0;
    unique case (state_d)
      ST_CLEAR, ST_POLICE: lamp[LAMP_RED]    = 1'b1;
      ST_GREEN:            lamp[LAMP_GREEN]  = 1'b1;
      ST_YELLOW:           lamp[LAMP_YELLOW] = 1'b1;
      ST_FLASH:            flash_d = (state_q == ST_FLASH) ? (flash_q ^ tick) : 1'b1;
      default:             lamp = '0;
    endcase
    if (lamp[LAMP_RED]) begin
      red_d = '1;
    end else if (lamp[LAMP_GREEN] || lamp[LAMP_YELLOW]) begin
      red_d = ~served;
    end
    if (lamp[LAMP_GREEN])  green_d  = served;
    if (lamp[LAMP_YELLOW]) yellow_d = served;
    if (state_d == ST_FLASH) yellow_d = {NPHASE{flash_d}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      phase_q  <= PW'(NPHASE - 1);
      red_q    <= '0;
      yellow_q <= '0;
      green_q  <= '0;
      walk_q   <= '0;
      pend_q   <= '0;
      flash_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      walk_q   <= walk_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
    end
  end

  assign red       = red_q;
  assign yellow    = yellow_q;
  assign green     = green_q;
  assign walk      = walk_q;
  assign phase_idx = phase_q;
  assign ped_pend  = pend_q;

  a_params: assert property (@(posedge clk) PARAMS_OK)
    else $error("traffic_phase_ctrl: illegal parameter set");

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: behavioural scoreboard plus scenario tasks.
module tb_traffic_phase_ctrl;

  localparam int NP = 4;
  localparam int GT = 5;
  localparam int YT = 2;
  localparam int CT = 1;
  localparam int PT = 8;
  localparam int S_OFF = 0, S_CLR = 1, S_GRN = 2, S_YEL = 3, S_POL = 4, S_FLS = 5;

  logic       clk = 1'b0;
  logic       rst_n, tick, en, pause, police, flash;
  logic [3:0] phase_en, ped_req;
  logic [3:0] red, yellow, green, walk, ped_pend;
  logic [1:0] phase_idx;
  logic [6:0] rest_time;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;
  logic [28:0] sb_q[$];

  int         m_st = S_OFF;
  int         m_ph = 3;
  int         m_rest = 0;
  logic [3:0] m_pend = '0;
  bit         m_walk = 1'b0;
  bit         m_fl = 1'b1;

  traffic_phase_ctrl #(
    .NPHASE(NP), .TW(7), .GREEN_T(GT), .YELLOW_T(YT), .CLEAR_T(CT), .PED_T(PT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .pause(pause),
    .police(police), .flash(flash), .phase_en(phase_en), .ped_req(ped_req),
    .red(red), .yellow(yellow), .green(green), .walk(walk),
    .phase_idx(phase_idx), .rest_time(rest_time), .ped_pend(ped_pend)
  );

  always #5 clk = ~clk;

  // Behavioural reference: advance one clock from the inputs seen at the edge.
  task automatic model_step();
    logic [3:0] pn;
    logic [1:0] ix;
    int found;
    pn = m_pend | ped_req;
    found = -1;
    if (!en) begin
      m_st = S_OFF; m_rest = 0; m_walk = 1'b0;
    end else if (police) begin
      m_st = S_POL; m_rest = 0; m_walk = 1'b0;
    end else if (flash) begin
      if (m_st == S_FLS) begin
        if (tick) m_fl = !m_fl;
      end else begin
        m_fl = 1'b1;
      end
      m_st = S_FLS; m_rest = 0; m_walk = 1'b0;
    end else if (!pause) begin
      if (m_st == S_OFF || m_st == S_POL || m_st == S_FLS) begin
        m_st = S_CLR; m_rest = CT;
      end else if (tick) begin
        if (m_rest > 1) begin
          m_rest = m_rest - 1;
        end else if (m_st == S_GRN) begin
          m_st = S_YEL; m_rest = YT; m_walk = 1'b0;
        end else if (m_st == S_YEL) begin
          m_st = S_CLR; m_rest = CT;
        end else begin
          for (int k = 1; k <= NP; k++) begin
            ix = 2'((m_ph + k) % NP);
            if (found < 0 && phase_en[ix]) found = int'(ix);
          end
          if (found < 0) begin
            m_rest = CT;
          end else begin
            ix = 2'(found);
            m_ph = found;
            m_st = S_GRN;
            m_walk = pn[ix];
            pn[ix] = 1'b0;
            m_rest = m_walk ? PT : GT;
          end
        end
      end
    end
    m_pend = pn;
  endtask

  function automatic logic [28:0] model_out();
    logic [3:0] oh, r, y, g, w;
    oh = 4'b0001 << m_ph;
    r = '0; y = '0; g = '0; w = '0;
    case (m_st)
      S_CLR, S_POL: r = 4'hf;
      S_GRN: begin g = oh; r = ~oh; w = m_walk ? oh : 4'h0; end
      S_YEL: begin y = oh; r = ~oh; end
      S_FLS: y = {4{m_fl}};
      default: r = '0;
    endcase
    return {r, y, g, w, 2'(m_ph), 7'(m_rest), m_pend};
  endfunction

  // Producer: expected outputs pushed on every edge the DUT also sees.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_st = S_OFF; m_ph = 3; m_rest = 0; m_pend = '0; m_walk = 1'b0; m_fl = 1'b1;
        sb_q.delete();
      end else if (model_on) begin
        model_step();
        sb_q.push_back(model_out());
      end
    end
  end

  // Consumer: compare DUT outputs mid-cycle against the oldest expectation.
  initial begin
    logic [28:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        act_v = {red, yellow, green, walk, phase_idx, rest_time, ped_pend};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL scoreboard t=%0t got r%b y%b g%b w%b ph%0d rt%0d pp%b exp r%b y%b g%b w%b ph%0d rt%0d pp%b",
                   $time, act_v[28:25], act_v[24:21], act_v[20:17], act_v[16:13], act_v[12:11],
                   act_v[10:4], act_v[3:0], exp_v[28:25], exp_v[24:21], exp_v[20:17],
                   exp_v[16:13], exp_v[12:11], exp_v[10:4], exp_v[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_green(input int ph, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      cyc(1);
      if (green === (4'b0001 << ph)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    checks++;
    if ({red, yellow, green, walk, ped_pend} !== 20'h0) begin
      errors++; $display("FAIL reset_lamps got %h exp 0", {red, yellow, green, walk, ped_pend});
    end
    checks++;
    if (phase_idx !== 2'd3 || rest_time !== 7'd0) begin
      errors++; $display("FAIL reset_idx got ph=%0d rt=%0d exp ph=3 rt=0", phase_idx, rest_time);
    end
    rst_n = 1'b1;
    model_on = 1'b1;
    cyc(1);
    checks++;
    if ({red, green} !== 8'h0 || rest_time !== 7'd0) begin
      errors++; $display("FAIL off_with_en0 got r=%b g=%b rt=%0d exp 0", red, green, rest_time);
    end
  endtask

  task automatic test_full_cycle();
    en = 1'b1;
    cyc(1);
    checks++;
    if (red !== 4'hf || rest_time !== 7'd1) begin
      errors++; $display("FAIL first_clear got r=%b rt=%0d exp r=1111 rt=1", red, rest_time);
    end
    cyc(1);
    checks++;
    if (green !== 4'b0001 || red !== 4'b1110 || rest_time !== 7'd5 || phase_idx !== 2'd0) begin
      errors++; $display("FAIL g0_entry got g=%b r=%b rt=%0d ph=%0d exp g=0001 rt=5", green, red, rest_time, phase_idx);
    end
    cyc(4);
    checks++;
    if (green !== 4'b0001 || rest_time !== 7'd1) begin
      errors++; $display("FAIL g0_last got g=%b rt=%0d exp g=0001 rt=1", green, rest_time);
    end
    cyc(1);
    checks++;
    if (yellow !== 4'b0001 || green !== 4'b0000 || rest_time !== 7'd2) begin
      errors++; $display("FAIL y0_entry got y=%b g=%b rt=%0d exp y=0001 rt=2", yellow, green, rest_time);
    end
    cyc(2);
    checks++;
    if (red !== 4'hf || yellow !== 4'h0) begin
      errors++; $display("FAIL clear_after_y0 got r=%b y=%b exp r=1111", red, yellow);
    end
    cyc(1);
    checks++;
    if (green !== 4'b0010 || phase_idx !== 2'd1) begin
      errors++; $display("FAIL g1_entry got g=%b ph=%0d exp g=0010 ph=1", green, phase_idx);
    end
    cyc(24);
    checks++;
    if (green !== 4'b0001 || rest_time !== 7'd5 || phase_idx !== 2'd0) begin
      errors++; $display("FAIL wrap_to_g0 got g=%b rt=%0d ph=%0d exp g=0001 rt=5 ph=0", green, rest_time, phase_idx);
    end
  endtask

  task automatic test_mask();
    phase_en = 4'b0101;
    cyc(8);
    checks++;
    if (green !== 4'b0100) begin
      errors++; $display("FAIL mask_skip_to_g2 got g=%b exp 0100", green);
    end
    cyc(8);
    checks++;
    if (green !== 4'b0001) begin
      errors++; $display("FAIL mask_back_to_g0 got g=%b exp 0001", green);
    end
    phase_en = 4'b0000;
    cyc(8);
    checks++;
    if (red !== 4'hf || rest_time !== 7'd1) begin
      errors++; $display("FAIL empty_mask_clear got r=%b rt=%0d exp r=1111 rt=1", red, rest_time);
    end
    cyc(5);
    checks++;
    if (red !== 4'hf || green !== 4'h0 || rest_time !== 7'd1) begin
      errors++; $display("FAIL empty_mask_held got r=%b g=%b rt=%0d exp r=1111 rt=1", red, green, rest_time);
    end
    phase_en = 4'b1111;
  endtask

  task automatic test_ped();
    bit ok;
    wait_green(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ped_wait_g0 got timeout exp green0"); end
    ped_req = 4'b0010;
    cyc(1);
    ped_req = 4'b0000;
    checks++;
    if (ped_pend !== 4'b0010) begin
      errors++; $display("FAIL ped_latch got %b exp 0010", ped_pend);
    end
    wait_green(1, ok);
    checks++;
    if (!ok || rest_time !== 7'd8 || walk !== 4'b0010 || ped_pend !== 4'b0000) begin
      errors++; $display("FAIL ped_g1_entry got rt=%0d w=%b pp=%b exp rt=8 w=0010 pp=0000", rest_time, walk, ped_pend);
    end
    ped_req = 4'b0010;
    cyc(1);
    ped_req = 4'b0000;
    checks++;
    if (ped_pend !== 4'b0010 || walk !== 4'b0010) begin
      errors++; $display("FAIL ped_during_green got pp=%b w=%b exp pp=0010 w=0010", ped_pend, walk);
    end
    cyc(6);
    checks++;
    if (green !== 4'b0010 || walk !== 4'b0010 || rest_time !== 7'd1) begin
      errors++; $display("FAIL ped_g1_last got g=%b w=%b rt=%0d exp g=0010 w=0010 rt=1", green, walk, rest_time);
    end
    cyc(1);
    checks++;
    if (yellow !== 4'b0010 || walk !== 4'b0000) begin
      errors++; $display("FAIL ped_y1 got y=%b w=%b exp y=0010 w=0000", yellow, walk);
    end
  endtask

  task automatic test_police();
    bit ok;
    wait_green(2, ok);
    cyc(2);
    checks++;
    if (!ok || green !== 4'b0100 || rest_time !== 7'd3) begin
      errors++; $display("FAIL police_setup got g=%b rt=%0d exp g=0100 rt=3", green, rest_time);
    end
    police = 1'b1;
    cyc(1);
    checks++;
    if (red !== 4'hf || green !== 4'h0 || rest_time !== 7'd0) begin
      errors++; $display("FAIL police_allred got r=%b g=%b rt=%0d exp r=1111 g=0 rt=0", red, green, rest_time);
    end
    cyc(3);
    police = 1'b0;
    cyc(1);
    checks++;
    if (red !== 4'hf || rest_time !== 7'd1 || phase_idx !== 2'd2) begin
      errors++; $display("FAIL police_release got r=%b rt=%0d ph=%0d exp r=1111 rt=1 ph=2", red, rest_time, phase_idx);
    end
    cyc(1);
    checks++;
    if (green !== 4'b1000) begin
      errors++; $display("FAIL police_resume got g=%b exp 1000", green);
    end
  endtask

  task automatic test_pause();
    bit ok;
    wait_green(1, ok);
    checks++;
    if (!ok || rest_time !== 7'd8 || walk !== 4'b0010) begin
      errors++; $display("FAIL held_ped_served got rt=%0d w=%b exp rt=8 w=0010", rest_time, walk);
    end
    cyc(8);
    pause = 1'b1;
    cyc(10);
    checks++;
    if (yellow !== 4'b0010 || rest_time !== 7'd2) begin
      errors++; $display("FAIL pause_hold got y=%b rt=%0d exp y=0010 rt=2", yellow, rest_time);
    end
    pause = 1'b0;
    cyc(1);
    checks++;
    if (rest_time !== 7'd1) begin
      errors++; $display("FAIL pause_resume got rt=%0d exp 1", rest_time);
    end
    cyc(1);
    checks++;
    if (red !== 4'hf || yellow !== 4'h0) begin
      errors++; $display("FAIL pause_to_clear got r=%b y=%b exp r=1111 y=0", red, yellow);
    end
  endtask

  task automatic test_flash();
    logic [3:0] pat;
    flash = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      pat = (i % 2 == 0) ? 4'hf : 4'h0;
      checks++;
      if (yellow !== pat || red !== 4'h0 || rest_time !== 7'd0) begin
        errors++; $display("FAIL flash_step%0d got y=%b r=%b rt=%0d exp y=%b r=0 rt=0", i, yellow, red, rest_time, pat);
      end
    end
    flash = 1'b0;
    cyc(1);
    checks++;
    if (red !== 4'hf || rest_time !== 7'd1) begin
      errors++; $display("FAIL flash_release got r=%b rt=%0d exp r=1111 rt=1", red, rest_time);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick    = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 59) != 0);
      police  = ($urandom_range(0, 39) == 0);
      flash   = ($urandom_range(0, 49) == 0);
      pause   = ($urandom_range(0, 9) == 0);
      ped_req = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      if ($urandom_range(0, 29) == 0) phase_en = 4'($urandom_range(0, 15));
      cyc(1);
    end
    tick = 1'b1; en = 1'b1; police = 1'b0; flash = 1'b0; pause = 1'b0;
    ped_req = 4'h0; phase_en = 4'hf;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_green(1, ok);
    ped_req = 4'b0100;
    cyc(1);
    ped_req = 4'b0000;
    checks++;
    if (!ok || green !== 4'b0010 || ped_pend[2] !== 1'b1) begin
      errors++; $display("FAIL pre_reset got g=%b pp=%b exp g=0010 pp[2]=1", green, ped_pend);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({red, yellow, green, walk, ped_pend} !== 20'h0 || phase_idx !== 2'd3 || rest_time !== 7'd0) begin
      errors++; $display("FAIL async_reset got lamps=%h ph=%0d rt=%0d exp 0 ph=3 rt=0",
                         {red, yellow, green, walk, ped_pend}, phase_idx, rest_time);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (green !== 4'b0001 || phase_idx !== 2'd0) begin
      errors++; $display("FAIL restart_g0 got g=%b ph=%0d exp g=0001 ph=0", green, phase_idx);
    end
    cyc(4);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b1; en = 1'b0; pause = 1'b0; police = 1'b0; flash = 1'b0;
    phase_en = 4'hf; ped_req = 4'h0;
    test_reset();
    test_full_cycle();
    test_mask();
    test_ped();
    test_police();
    test_pause();
    test_flash();
    test_random();
    test_reset_mid();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
